// File: rtl/controller_sseg_rd_status.sv
// controller_sseg_rd_status: Avalon-MM status input port with sync, debounce, edge capture and maskable irq
module controller_sseg_rd_status #(
  parameter int WIDTH = 4,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [WIDTH-1:0] s1, s2, db, db_d, ec, irqmask, rise, fall, ev, clr;
  logic [CW-1:0] cnt [WIDTH];
  logic rd, wr;
  logic [31:0] rd_mux;
  always_comb begin
    rd = chipselect & ~read_n;
    wr = chipselect & ~write_n;
    rise = db & ~db_d;
    fall = ~db & db_d;
    ev = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);
    clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    rd_mux = (address == 2'd0) ? 32'(db) :
             (address == 2'd2) ? 32'(irqmask) :
             (address == 2'd3) ? 32'(ec) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_d <= '0;
      ec <= '0;
      irqmask <= '0;
      readdata <= '0;
      irq <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      db_d <= db;
      // db only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
      ec <= ev | (ec & ~clr);
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      if (rd) readdata <= rd_mux;
      irq <= |(ec & irqmask);
    end
  end
endmodule

// File: tb/tb_controller_sseg_rd_status.sv
// tb_controller_sseg_rd_status: three edge-type instances driven together, checked by a scoreboard against a window-based reference model
module tb_controller_sseg_rd_status;
  localparam int W = 4;
  localparam int DC = 16;
  localparam int N = DC + 2;
  logic clk = 0;
  logic reset = 1;
  logic [1:0] address = 0;
  logic chipselect = 0;
  logic read_n = 1;
  logic write_n = 1;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = 0;
  logic [31:0] readdata_a [3];
  logic irq_a [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    controller_sseg_rd_status #(.WIDTH(W), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_a[g]), .irq(irq_a[g])
    );
  end

  typedef struct packed { logic [2:0][31:0] rd; } exp_t;
  exp_t sbq [$];
  logic [W-1:0] hist [$];
  logic [W-1:0] m_db = 0, m_dbd = 0;
  logic [W-1:0] m_ec [3];
  logic [W-1:0] m_mask [3];
  logic m_irq [3];
  int checks = 0, errors = 0;
  bit started = 0, rst_seen = 0, done = 0, final_checked = 0;

  // Reference: a debounced bit flips once the last DC synchronized samples all disagree with it
  always @(posedge clk) begin : model
    logic [W-1:0] nd, ev, clr;
    logic rdv, wrv, alld;
    exp_t e;
    started = 1;
    rst_seen = reset;
    if (reset) begin
      hist.delete();
      repeat (N) hist.push_back('0);
      m_db = '0;
      m_dbd = '0;
      for (int k = 0; k < 3; k++) begin
        m_ec[k] = '0;
        m_mask[k] = '0;
        m_irq[k] = 0;
      end
    end else begin
      rdv = chipselect && !read_n;
      wrv = chipselect && !write_n;
      clr = (wrv && address == 2'd3) ? writedata[W-1:0] : '0;
      nd = m_db;
      for (int i = 0; i < W; i++) begin
        alld = 1;
        for (int j = 1; j <= DC; j++) if (hist[j][i] == m_db[i]) alld = 0;
        if (alld) nd[i] = ~m_db[i];
      end
      e = '0;
      for (int k = 0; k < 3; k++) begin
        ev = (k == 0) ? (m_db & ~m_dbd) : (k == 1) ? (~m_db & m_dbd) : (m_db ^ m_dbd);
        case (address)
          2'd0: e.rd[k] = 32'(m_db);
          2'd2: e.rd[k] = 32'(m_mask[k]);
          2'd3: e.rd[k] = 32'(m_ec[k]);
          default: e.rd[k] = 32'd0;
        endcase
        m_irq[k] = |(m_ec[k] & m_mask[k]);
        m_ec[k] = ev | (m_ec[k] & ~clr);
        if (wrv && address == 2'd2) m_mask[k] = writedata[W-1:0];
      end
      if (rdv) sbq.push_back(e);
      m_dbd = m_db;
      m_db = nd;
      hist.push_back(in_port);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (started) begin
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (readdata_a[k] !== e.rd[k]) begin
            errors++;
            $display("FAIL readdata edge_type=%0d t=%0t got %h want %h", k, $time, readdata_a[k], e.rd[k]);
          end
        end
      end
      if (rst_seen)
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (readdata_a[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset_readdata edge_type=%0d t=%0t got %h want 0", k, $time, readdata_a[k]);
          end
        end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (irq_a[k] !== m_irq[k]) begin
          errors++;
          $display("FAIL irq edge_type=%0d t=%0t got %b want %b", k, $time, irq_a[k], m_irq[k]);
        end
      end
      if (done && !final_checked) begin
        final_checked = 1;
        checks++;
        if (sbq.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
      end
    end
  end

  task automatic bus(input bit cs, input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs;
    read_n = !r;
    write_n = !w;
    address = a;
    writedata = d;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) bus(0, 0, 0, 2'd0, 32'd0);
  endtask
  task automatic rd_reg(input logic [1:0] a);
    bus(1, 1, 0, a, 32'd0);
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus(1, 0, 1, a, d);
  endtask

  initial begin
    int r;
    reset = 1;
    in_port = 4'hF;
    @(negedge clk);
    idle(3);
    reset = 0;
    idle(16);
    rd_reg(0);
    idle(1);
    rd_reg(0);
    rd_reg(3);
    wr_reg(3, 32'hF);
    rd_reg(3);
    in_port = 4'h0;
    idle(22);
    rd_reg(0);
    rd_reg(3);
    wr_reg(3, 32'hF);
    // glitch shorter than the filter, then a qualifying pulse
    in_port[1] = 1;
    idle(10);
    in_port[1] = 0;
    idle(22);
    rd_reg(0);
    rd_reg(3);
    in_port[1] = 1;
    idle(20);
    rd_reg(0);
    rd_reg(3);
    in_port[1] = 0;
    idle(22);
    wr_reg(3, 32'hF);
    wr_reg(2, 32'h4);
    in_port[2] = 1;
    idle(22);
    rd_reg(3);
    wr_reg(3, 32'h4);
    idle(3);
    in_port[2] = 0;
    idle(22);
    wr_reg(3, 32'hF);
    wr_reg(2, 32'h0);
    in_port[0] = 1;
    idle(22);
    rd_reg(3);
    wr_reg(2, 32'h1);
    idle(3);
    wr_reg(3, 32'hF);
    in_port[0] = 0;
    idle(22);
    rd_reg(3);
    wr_reg(3, 32'hF);
    // continuous clear plus read of edgecapture while bit 3 edges
    wr_reg(2, 32'h8);
    in_port[3] = 1;
    repeat (25) bus(1, 1, 1, 2'd3, 32'h8);
    rd_reg(2);
    in_port[3] = 0;
    idle(22);
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1;
        idle(2);
        reset = 0;
      end
      r = $urandom_range(0, 9);
      if (r < 3) bus($urandom_range(0, 7) != 0, 1, 0, 2'($urandom_range(0, 3)), $urandom);
      else if (r < 5) bus($urandom_range(0, 7) != 0, 0, 1, 2'($urandom_range(0, 3)), $urandom);
      else if (r == 5) bus($urandom_range(0, 7) != 0, 1, 1, 2'($urandom_range(0, 3)), $urandom);
      else idle(1);
    end
    idle(3);
    done = 1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
